prio_encoder_drain: RTL and testbench

Parametrised N-input priority encoder that captures a request bit-vector and then emits the binary code of every set bit, one per handshake beat, until the vector is empty.
- Two selection modes: fixed priority (lowest index wins) and round-robin (search starts after the last granted index).
- Sits between a request-collecting stage and a downstream consumer that services one index at a time.
- Generalises the 4-bit combinational encoder: width, mode, valid output, backpressure and a remaining-count.

---
 rtl/prio_pkg.sv | 24 ++
 rtl/prio_lsb_enc.sv | 22 ++
 rtl/prio_encoder_drain.sv | 143 ++++++++++++++
 tb/tb_prio_encoder_drain.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared types, mode constants and popcount helper for the draining priority encoder.
package prio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Vectors wider than 64 bits are not supported by this helper.
  localparam int unsigned POP_W = 64;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_lsb_enc.sv
// Combinational lowest-set-bit encoder: idx is the lowest set index of vec, found=|vec.
module prio_lsb_enc #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !found) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_drain.sv
// Captures a request vector and emits the code of every set bit, one per handshake beat,
// in fixed-priority or round-robin order; all outputs come straight from flops.
module prio_encoder_drain
  import prio_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] code,
  output logic         any,
  output logic         last,
  output logic [W:0]   remaining
);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         mode_q, mode_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         req_ready_q, req_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] code_q, code_d;
  logic         any_q, any_d;
  logic         last_q, last_d;
  logic [W:0]   rem_q, rem_d;

  logic [N-1:0] rr_mask;
  logic [N-1:0] masked_vec;
  logic [W-1:0] m_idx, u_idx;
  logic         m_found, u_found;

  // Next-state: accept in IDLE, retire the currently presented beat in BUSY.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pend_d  = req;
          mode_d  = mode;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (any_q) begin
            pend_d = pend_q & ~(N'(1) << code_q);
            if (mode_q == MODE_RR) begin
              ptr_d = (code_q == W'(N - 1)) ? '0 : code_q + W'(1);
            end
          end
          if (last_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selection runs on next-state values so the presented beat can be registered.
  always_comb begin
    rr_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_mask[i] = (i >= 32'(ptr_d));
    end
  end

  assign masked_vec = pend_d & rr_mask;

  prio_lsb_enc #(.N(N)) u_enc_masked (
    .vec   (masked_vec),
    .idx   (m_idx),
    .found (m_found)
  );

  prio_lsb_enc #(.N(N)) u_enc_full (
    .vec   (pend_d),
    .idx   (u_idx),
    .found (u_found)
  );

  always_comb begin
    req_ready_d = 1'b1;
    out_valid_d = 1'b0;
    code_d      = '0;
    any_d       = 1'b0;
    last_d      = 1'b0;
    rem_d       = '0;
    if (state_d == BUSY) begin
      req_ready_d = 1'b0;
      out_valid_d = 1'b1;
      code_d      = (mode_d == MODE_RR && m_found) ? m_idx : u_idx;
      any_d       = u_found;
      rem_d       = (W+1)'(popcount(POP_W'(pend_d)));
      last_d      = (rem_d <= (W+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mode_q      <= MODE_FIXED;
      ptr_q       <= '0;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      any_q       <= 1'b0;
      last_q      <= 1'b0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      any_q       <= any_d;
      last_q      <= last_d;
      rem_q       <= rem_d;
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign any       = any_q;
  assign last      = last_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_prio_encoder_drain.sv
// Directed plus random bench for prio_encoder_drain against a beat-list reference model.
module tb_prio_encoder_drain;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic [N-1:0] req = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] code;
  logic         any;
  logic         last;
  logic [W:0]   remaining;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int code;
    bit any;
    bit last;
    int rem;
  } beat_t;

  beat_t exp_q[$];
  int    mptr = 0;

  prio_encoder_drain #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .any       (any),
    .last      (last),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: list every beat the vector should produce, straight from the selection rules.
  task automatic build_exp(input logic [N-1:0] v_in, input bit m);
    logic [N-1:0] v;
    int cnt, idx;
    beat_t b;
    v   = v_in;
    cnt = $countones(v);
    if (cnt == 0) begin
      b = '{code: 0, any: 1'b0, last: 1'b1, rem: 0};
      exp_q.push_back(b);
    end
    while (cnt > 0) begin
      idx = -1;
      if (m) begin
        for (int i = mptr; i < N; i++) if (idx < 0 && v[i]) idx = i;
      end
      for (int i = 0; i < N; i++) if (idx < 0 && v[i]) idx = i;
      b = '{code: idx, any: 1'b1, last: (cnt == 1), rem: cnt};
      exp_q.push_back(b);
      v[idx] = 1'b0;
      cnt--;
      if (m) mptr = (idx + 1) % N;
    end
  endtask

  task automatic chk_beat(input beat_t b);
    chk("out_valid", 32'(out_valid), 1);
    chk("req_ready_busy", 32'(req_ready), 0);
    chk("code", 32'(code), b.code);
    chk("any", 32'(any), 32'(b.any));
    chk("last", 32'(last), 32'(b.last));
    chk("remaining", 32'(remaining), b.rem);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
  endtask

  // Starts at a falling edge with the DUT idle; ends on the idle bubble after the last beat.
  task automatic run_vector(input logic [N-1:0] v, input bit m, input int force_stall,
                            input bit pulse, input int ready_pct);
    beat_t b;
    int    stalls;
    bit    go;
    req       = v;
    mode      = m;
    req_valid = 1'b1;
    build_exp(v, m);
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() > 0) begin
      b      = exp_q[0];
      stalls = 0;
      go     = 1'b0;
      while (!go) begin
        chk_beat(b);
        go = (stalls >= force_stall) &&
             ((stalls >= force_stall + 4) || ($urandom_range(99) < 32'(ready_pct)));
        if (go) begin
          out_ready = 1'b1;
          req_valid = 1'b0;
        end else begin
          out_ready = 1'b0;
          if (pulse) begin
            req_valid = 1'b1;
            req       = N'($urandom);
            mode      = 1'($urandom);
          end
          stalls++;
        end
        @(negedge clk);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b0;
    end
    req_valid = 1'b0;
    chk_idle("bubble");
  endtask

  initial begin
    beat_t b;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_any", 32'(any), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_remaining", 32'(remaining), 0);

    // Fixed priority drain
    run_vector(8'b1010_0110, 1'b0, 0, 1'b0, 100);

    // Round-robin: pointer advances past 5, then wraps through 6,7,0,1
    run_vector(8'b0010_0000, 1'b1, 0, 1'b0, 100);
    run_vector(8'b1100_0011, 1'b1, 0, 1'b0, 100);

    // Zero vector in round-robin must leave the pointer at 2
    run_vector(8'h00, 1'b1, 0, 1'b0, 100);
    run_vector(8'b0000_0111, 1'b1, 0, 1'b0, 100);
    run_vector(8'h00, 1'b0, 0, 1'b0, 100);

    // Backpressure with req_valid pulses while busy
    run_vector(8'b0001_1000, 1'b0, 3, 1'b1, 100);

    // Single-bit vector
    run_vector(8'b0000_0001, 1'b0, 0, 1'b0, 100);

    // Reset mid-drain
    req       = 8'hFF;
    mode      = 1'b1;
    req_valid = 1'b1;
    build_exp(8'hFF, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b = exp_q.pop_front();
      chk_beat(b);
      out_ready = 1'b1;
      @(negedge clk);
    end
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mptr = 0;
    chk_idle("midrst");
    chk("midrst_remaining", 32'(remaining), 0);
    @(negedge clk);
    chk_idle("midrst_hold");
    run_vector(8'h80, 1'b1, 0, 1'b0, 100);
    run_vector(8'hFF, 1'b1, 0, 1'b0, 100);

    // Random vectors, modes and backpressure
    for (int t = 0; t < 60; t++) begin
      run_vector(N'($urandom), 1'($urandom), 0, 1'($urandom), 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
